// File: rtl/riscv_mmio_timer.sv
// Memory-mapped timer on the core data port: prescaled 32-bit up-counter with
// compare match, auto-reload, saturating match counter and a level interrupt.
module riscv_mmio_timer #(
    parameter logic [31:0] BASE_ADDR  = 32'h1000_0000,
    parameter int unsigned PRESCALE_W = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        data_ce_i,
    input  logic        data_we_i,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_wdata_i,
    output logic [31:0] data_rdata_o,
    output logic        sel_o,
    output logic        irq_o
);
    localparam logic [5:0] IDX_CTRL     = 6'd0;
    localparam logic [5:0] IDX_PRESCALE = 6'd1;
    localparam logic [5:0] IDX_COUNT    = 6'd2;
    localparam logic [5:0] IDX_COMPARE  = 6'd3;
    localparam logic [5:0] IDX_STATUS   = 6'd4;
    localparam logic [5:0] IDX_MATCHCNT = 6'd5;

    logic [2:0]            ctrl_q, ctrl_d;
    logic [PRESCALE_W-1:0] prescale_q, prescale_d;
    logic [PRESCALE_W-1:0] pre_cnt_q, pre_cnt_d;
    logic [31:0]           count_q, count_d;
    logic [31:0]           compare_q, compare_d;
    logic                  match_q, match_d;
    logic [7:0]            matchcnt_q, matchcnt_d;

    logic       hit;
    logic       wr;
    logic [5:0] idx;
    logic       tick;
    logic       match_evt;
    logic       unused_addr_lsb;

    assign hit             = data_ce_i && (data_addr_i[31:8] == BASE_ADDR[31:8]);
    assign wr              = hit && data_we_i;
    assign idx             = data_addr_i[7:2];
    assign sel_o           = hit;
    assign unused_addr_lsb = ^data_addr_i[1:0];

    assign tick      = ctrl_q[0] && (pre_cnt_q == prescale_q);
    // A CPU write to COUNT suppresses the compare for that cycle.
    assign match_evt = tick && !(wr && idx == IDX_COUNT) && (count_q == compare_q);

    assign irq_o = match_q & ctrl_q[2];

    always_comb begin
        data_rdata_o = 32'h0;
        if (hit && !data_we_i) begin
            case (idx)
                IDX_CTRL:     data_rdata_o = {29'h0, ctrl_q};
                IDX_PRESCALE: data_rdata_o = 32'(prescale_q);
                IDX_COUNT:    data_rdata_o = count_q;
                IDX_COMPARE:  data_rdata_o = compare_q;
                IDX_STATUS:   data_rdata_o = {31'h0, match_q};
                IDX_MATCHCNT: data_rdata_o = {24'h0, matchcnt_q};
                default:      data_rdata_o = 32'h0;
            endcase
        end
    end

    always_comb begin
        ctrl_d     = ctrl_q;
        prescale_d = prescale_q;
        pre_cnt_d  = pre_cnt_q;
        count_d    = count_q;
        compare_d  = compare_q;
        match_d    = match_q;
        matchcnt_d = matchcnt_q;

        if (wr && idx == IDX_PRESCALE) begin
            pre_cnt_d = '0;
        end else if (ctrl_q[0]) begin
            pre_cnt_d = tick ? '0 : pre_cnt_q + PRESCALE_W'(1);
        end

        if (wr && idx == IDX_COUNT) begin
            count_d = data_wdata_i;
        end else if (tick) begin
            count_d = (match_evt && ctrl_q[1]) ? 32'h0 : count_q + 32'd1;
        end

        // Set beats write-1-clear on STATUS; clear beats increment on MATCHCNT.
        if (match_evt) begin
            match_d = 1'b1;
        end else if (wr && idx == IDX_STATUS && data_wdata_i[0]) begin
            match_d = 1'b0;
        end

        if (wr && idx == IDX_MATCHCNT) begin
            matchcnt_d = 8'h0;
        end else if (match_evt && matchcnt_q != 8'hFF) begin
            matchcnt_d = matchcnt_q + 8'd1;
        end

        if (wr && idx == IDX_CTRL)     ctrl_d     = data_wdata_i[2:0];
        if (wr && idx == IDX_PRESCALE) prescale_d = data_wdata_i[PRESCALE_W-1:0];
        if (wr && idx == IDX_COMPARE)  compare_d  = data_wdata_i;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_q     <= 3'h0;
            prescale_q <= '0;
            pre_cnt_q  <= '0;
            count_q    <= 32'h0;
            compare_q  <= 32'hFFFF_FFFF;
            match_q    <= 1'b0;
            matchcnt_q <= 8'h0;
        end else begin
            ctrl_q     <= ctrl_d;
            prescale_q <= prescale_d;
            pre_cnt_q  <= pre_cnt_d;
            count_q    <= count_d;
            compare_q  <= compare_d;
            match_q    <= match_d;
            matchcnt_q <= matchcnt_d;
        end
    end

endmodule
